// File: rtl/pipelined_address_generator_if.sv
// Request/result bus of the pipelined address generator.
//   Request side : in_valid/in_ready handshake, opcode, funct3, rs1, pc,
//                  immediate, tag_in.
//   Result side  : out_valid/out_ready handshake, address, misaligned,
//                  illegal, carry_out, tag_out.
// The master modport belongs to the decode stage that issues requests and
// consumes results; the slave modport belongs to the generator itself.
interface pipelined_address_generator_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [XLEN-1:0]  rs1;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  immediate;
    logic [TAG_W-1:0] tag_in;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  address;
    logic             misaligned;
    logic             illegal;
    logic             carry_out;
    logic [TAG_W-1:0] tag_out;

    modport master (
        output in_valid, opcode, funct3, rs1, pc, immediate, tag_in, out_ready,
        input  in_ready, out_valid, address, misaligned, illegal, carry_out, tag_out
    );

    modport slave (
        input  in_valid, opcode, funct3, rs1, pc, immediate, tag_in, out_ready,
        output in_ready, out_valid, address, misaligned, illegal, carry_out, tag_out
    );
endinterface

// File: rtl/pipelined_address_generator.sv
// Pipelined effective/target address generator.
// Adds rs1+imm (LOAD/STORE/JALR) or pc+imm (JAL/AUIPC/BRANCH) in a
// Kogge-Stone prefix adder, clears bit 0 for JALR, flags misalignment and
// unsupported opcodes, and passes a sideband tag through unchanged.
// Ports:
//   clk   - clock
//   reset - synchronous active-low reset
//   flush - kills every in-flight entry on the next edge
//   bus   - request/result bus (slave modport), valid/ready on both sides
// LATENCY=1: a single output register. LATENCY=2: an extra register after
// prefix level ceil(log2(XLEN)/2) holding the partial generate/propagate.
module pipelined_address_generator #(
    parameter int XLEN    = 32,
    parameter int LATENCY = 1,
    parameter int C_EXT   = 0,
    parameter int TAG_W   = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic flush,
    pipelined_address_generator_if.slave bus
);
    localparam int LOG   = $clog2(XLEN);
    localparam int SPLIT = (LOG + 1) / 2;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic             is_mem;
        logic             is_ctrl;
        logic             is_jalr;
        logic             illegal;
        logic [1:0]       size;
        logic [TAG_W-1:0] tag;
    } side_t;

    // Prefix levels lo..hi-1; level k combines spans 2^k apart. Bits below
    // the span keep their generate and propagate unchanged.
    function automatic logic [2*XLEN-1:0] ks_span(input logic [XLEN-1:0] g_in,
                                                  input logic [XLEN-1:0] p_in,
                                                  input int lo, input int hi);
        logic [XLEN-1:0] g;
        logic [XLEN-1:0] p;
        logic [XLEN-1:0] low;
        g = g_in;
        p = p_in;
        for (int k = lo; k < hi; k++) begin
            low = ~({XLEN{1'b1}} << (1 << k));
            g   = g | (p & (g << (1 << k)));
            p   = p & ((p << (1 << k)) | low);
        end
        return {g, p};
    endfunction

    logic [XLEN-1:0] op_a, op_b, g0_f, p0_f, g_mid_f, p_mid_f;
    side_t           side_f;
    logic [XLEN-1:0] g_mid, p_mid, p0_mid, g_fin, unused_p_fin, addr;
    side_t           side_mid;
    logic            mis, cout;
    logic            out_free, s1_adv, in_ready, accept, load_out;
    logic            unused_funct3;

    logic            s1_valid_q, s1_valid_d;
    logic [XLEN-1:0] s1_g_q, s1_g_d, s1_p_q, s1_p_d, s1_p0_q, s1_p0_d;
    side_t           s1_side_q, s1_side_d;
    logic             out_valid_q, out_valid_d;
    logic [XLEN-1:0]  address_q, address_d;
    logic             misaligned_q, misaligned_d;
    logic             illegal_q, illegal_d;
    logic             carry_out_q, carry_out_d;
    logic [TAG_W-1:0] tag_out_q, tag_out_d;

    assign unused_funct3 = bus.funct3[2];

    // NOTE: every signal written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin : front_decode
        op_a        = '0;
        op_b        = '0;
        side_f      = '0;
        side_f.size = bus.funct3[1:0];
        side_f.tag  = bus.tag_in;
        case (bus.opcode)
            OP_LOAD, OP_STORE: begin
                op_a           = bus.rs1;
                op_b           = bus.immediate;
                side_f.is_mem  = 1'b1;
                side_f.illegal = (bus.funct3[1:0] == 2'b11);
            end
            OP_JALR: begin
                op_a           = bus.rs1;
                op_b           = bus.immediate;
                side_f.is_ctrl = 1'b1;
                side_f.is_jalr = 1'b1;
            end
            OP_JAL, OP_BRANCH: begin
                op_a           = bus.pc;
                op_b           = bus.immediate;
                side_f.is_ctrl = 1'b1;
            end
            OP_AUIPC: begin
                op_a = bus.pc;
                op_b = bus.immediate;
            end
            default: side_f.illegal = 1'b1;
        endcase
        g0_f = op_a & op_b;
        p0_f = op_a ^ op_b;
        {g_mid_f, p_mid_f} = ks_span(g0_f, p0_f, 0, SPLIT);
    end

    // Back half of the adder sees either the stage-1 register or the front
    // half directly, depending on LATENCY.
    always_comb begin : back_end
        if (LATENCY == 2) begin
            g_mid    = s1_g_q;
            p_mid    = s1_p_q;
            p0_mid   = s1_p0_q;
            side_mid = s1_side_q;
        end else begin
            g_mid    = g_mid_f;
            p_mid    = p_mid_f;
            p0_mid   = p0_f;
            side_mid = side_f;
        end
        {g_fin, unused_p_fin} = ks_span(g_mid, p_mid, SPLIT, LOG);
        addr = p0_mid ^ {g_fin[XLEN-2:0], 1'b0};
        cout = g_fin[XLEN-1];
        if (side_mid.is_jalr) addr[0] = 1'b0;
        mis = 1'b0;
        if (side_mid.is_ctrl) begin
            mis = (C_EXT == 0) && addr[1];
        end else if (side_mid.is_mem) begin
            case (side_mid.size)
                2'b01:   mis = addr[0];
                2'b10:   mis = |addr[1:0];
                default: mis = 1'b0;
            endcase
        end
    end

    always_comb begin : handshake
        out_free = !out_valid_q || bus.out_ready;
        s1_adv   = s1_valid_q && out_free;
        if (LATENCY == 2) in_ready = reset && !flush && (!s1_valid_q || s1_adv);
        else              in_ready = reset && !flush && out_free;
        accept   = bus.in_valid && in_ready;
        load_out = ((LATENCY == 2) ? s1_adv : accept) && !flush;

        s1_valid_d = s1_valid_q;
        if (flush || LATENCY != 2) s1_valid_d = 1'b0;
        else if (accept)           s1_valid_d = 1'b1;
        else if (s1_adv)           s1_valid_d = 1'b0;
        s1_g_d    = accept ? g_mid_f : s1_g_q;
        s1_p_d    = accept ? p_mid_f : s1_p_q;
        s1_p0_d   = accept ? p0_f    : s1_p0_q;
        s1_side_d = accept ? side_f  : s1_side_q;

        out_valid_d = out_valid_q;
        if (flush)              out_valid_d = 1'b0;
        else if (load_out)      out_valid_d = 1'b1;
        else if (bus.out_ready) out_valid_d = 1'b0;
        address_d    = load_out ? addr             : address_q;
        misaligned_d = load_out ? mis              : misaligned_q;
        illegal_d    = load_out ? side_mid.illegal : illegal_q;
        carry_out_d  = load_out ? cout             : carry_out_q;
        tag_out_d    = load_out ? side_mid.tag     : tag_out_q;
    end

    // NOTE: sequential state is written with non-blocking assignments so all
    // flops sample their _d values from the same edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_valid_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            address_q    <= '0;
            misaligned_q <= 1'b0;
            illegal_q    <= 1'b0;
            carry_out_q  <= 1'b0;
            tag_out_q    <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            out_valid_q  <= out_valid_d;
            address_q    <= address_d;
            misaligned_q <= misaligned_d;
            illegal_q    <= illegal_d;
            carry_out_q  <= carry_out_d;
            tag_out_q    <= tag_out_d;
        end
    end

    // NOTE: stage-1 data is only observed behind s1_valid_q, so it needs no
    // reset; only the valid bit and the visible outputs are cleared.
    always_ff @(posedge clk) begin
        s1_g_q    <= s1_g_d;
        s1_p_q    <= s1_p_d;
        s1_p0_q   <= s1_p0_d;
        s1_side_q <= s1_side_d;
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.address    = address_q;
    assign bus.misaligned = misaligned_q;
    assign bus.illegal    = illegal_q;
    assign bus.carry_out  = carry_out_q;
    assign bus.tag_out    = tag_out_q;
endmodule

// File: tb/tb_pipelined_address_generator.sv
// Directed bench for pipelined_address_generator.
//   dut_a: XLEN=32, LATENCY=1, C_EXT=0
//   dut_b: XLEN=32, LATENCY=2, C_EXT=1
//   dut_c: XLEN=64, LATENCY=1, C_EXT=0
// Inputs change 1 time unit after the rising edge; outputs are read there.
module tb_pipelined_address_generator;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] OP     = 7'b0110011;

    logic clk = 1'b0;
    logic reset;
    logic flush;
    int   total = 0;
    int   bad   = 0;
    logic [31:0] e32;

    always #5 clk = ~clk;

    pipelined_address_generator_if #(.XLEN(32), .TAG_W(5)) ifa ();
    pipelined_address_generator_if #(.XLEN(32), .TAG_W(5)) ifb ();
    pipelined_address_generator_if #(.XLEN(64), .TAG_W(5)) ifc ();

    pipelined_address_generator #(.XLEN(32), .LATENCY(1), .C_EXT(0), .TAG_W(5)) dut_a (
        .clk(clk), .reset(reset), .flush(flush), .bus(ifa));
    pipelined_address_generator #(.XLEN(32), .LATENCY(2), .C_EXT(1), .TAG_W(5)) dut_b (
        .clk(clk), .reset(reset), .flush(flush), .bus(ifb));
    pipelined_address_generator #(.XLEN(64), .LATENCY(1), .C_EXT(0), .TAG_W(5)) dut_c (
        .clk(clk), .reset(reset), .flush(flush), .bus(ifc));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_b(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] r,
                         input logic [31:0] p, input logic [31:0] im, input logic [4:0] tg);
        ifb.opcode = op; ifb.funct3 = f3; ifb.rs1 = r; ifb.pc = p;
        ifb.immediate = im; ifb.tag_in = tg; ifb.in_valid = 1'b1;
    endtask

    // One request through dut_a (latency 1): offer, accept, check result.
    task automatic a_one(input string nm, input logic [6:0] op, input logic [2:0] f3,
                         input logic [31:0] r, input logic [31:0] p, input logic [31:0] im,
                         input logic [4:0] tg, input logic [31:0] e_addr,
                         input logic e_mis, input logic e_ill, input logic e_co);
        ifa.opcode = op; ifa.funct3 = f3; ifa.rs1 = r; ifa.pc = p;
        ifa.immediate = im; ifa.tag_in = tg; ifa.in_valid = 1'b1;
        #1 check({nm, "_rdy"}, ifa.in_ready, 1'b1);
        tick();
        ifa.in_valid = 1'b0;
        check({nm, "_vld"},  ifa.out_valid, 1'b1);
        check({nm, "_addr"}, ifa.address, e_addr);
        check({nm, "_mis"},  ifa.misaligned, e_mis);
        check({nm, "_ill"},  ifa.illegal, e_ill);
        check({nm, "_co"},   ifa.carry_out, e_co);
        check({nm, "_tag"},  ifa.tag_out, tg);
    endtask

    task automatic c_one(input string nm, input logic [6:0] op, input logic [2:0] f3,
                         input logic [63:0] r, input logic [63:0] p, input logic [63:0] im,
                         input logic [4:0] tg, input logic [63:0] e_addr,
                         input logic e_mis, input logic e_ill, input logic e_co);
        ifc.opcode = op; ifc.funct3 = f3; ifc.rs1 = r; ifc.pc = p;
        ifc.immediate = im; ifc.tag_in = tg; ifc.in_valid = 1'b1;
        tick();
        ifc.in_valid = 1'b0;
        check({nm, "_vld"},  ifc.out_valid, 1'b1);
        check({nm, "_addr"}, ifc.address, e_addr);
        check({nm, "_mis"},  ifc.misaligned, e_mis);
        check({nm, "_ill"},  ifc.illegal, e_ill);
        check({nm, "_co"},   ifc.carry_out, e_co);
        check({nm, "_tag"},  ifc.tag_out, tg);
    endtask

    initial begin
        reset = 1'b0;
        flush = 1'b0;
        ifa.in_valid = 1'b0; ifa.out_ready = 1'b1; ifa.opcode = '0; ifa.funct3 = '0;
        ifa.rs1 = '0; ifa.pc = '0; ifa.immediate = '0; ifa.tag_in = '0;
        ifb.in_valid = 1'b0; ifb.out_ready = 1'b1; ifb.opcode = '0; ifb.funct3 = '0;
        ifb.rs1 = '0; ifb.pc = '0; ifb.immediate = '0; ifb.tag_in = '0;
        ifc.in_valid = 1'b0; ifc.out_ready = 1'b1; ifc.opcode = '0; ifc.funct3 = '0;
        ifc.rs1 = '0; ifc.pc = '0; ifc.immediate = '0; ifc.tag_in = '0;
        repeat (2) tick();

        // Reset state
        check("rst_vld_a",  ifa.out_valid, 1'b0);
        check("rst_addr_a", ifa.address, 32'h0);
        check("rst_rdy_a",  ifa.in_ready, 1'b0);
        check("rst_vld_b",  ifb.out_valid, 1'b0);
        reset = 1'b1;
        #1 check("rel_rdy_a", ifa.in_ready, 1'b1);
        tick();

        // dut_a: latency 1, C_EXT=0
        a_one("lw_wrap",  LOAD,   3'b010, 32'h0000_1000, 32'h0, 32'hFFFF_FFFC, 5'd3,
              32'h0000_0FFC, 1'b0, 1'b0, 1'b1);
        a_one("jalr_c0",  JALR,   3'b000, 32'h8000_0001, 32'h0, 32'h0000_0002, 5'd4,
              32'h8000_0002, 1'b1, 1'b0, 1'b0);
        a_one("op_ill",   OP,     3'b000, 32'h0000_0055, 32'h10, 32'h0000_0007, 5'd5,
              32'h0, 1'b0, 1'b1, 1'b0);
        a_one("lh_odd",   LOAD,   3'b001, 32'h0000_0101, 32'h0, 32'h0, 5'd6,
              32'h0000_0101, 1'b1, 1'b0, 1'b0);
        a_one("lb_ovf",   LOAD,   3'b000, 32'hFFFF_FFFF, 32'h0, 32'h0000_0001, 5'd7,
              32'h0, 1'b0, 1'b0, 1'b1);
        a_one("sw_odd",   STORE,  3'b010, 32'h7FFF_FFFE, 32'h0, 32'h0000_0001, 5'd8,
              32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0);
        a_one("br_neg",   BRANCH, 3'b000, 32'h0, 32'h0000_0100, 32'hFFFF_FFFE, 5'd9,
              32'h0000_00FE, 1'b1, 1'b0, 1'b1);
        a_one("jal_ok",   JAL,    3'b000, 32'h0, 32'h0000_2000, 32'h0000_0010, 5'd10,
              32'h0000_2010, 1'b0, 1'b0, 1'b0);
        a_one("auipc",    AUIPC,  3'b000, 32'h0, 32'h1234_5002, 32'h0000_1000, 5'd11,
              32'h1234_6002, 1'b0, 1'b0, 1'b0);
        a_one("jalr_clr", JALR,   3'b000, 32'h0000_0101, 32'h0, 32'h0, 5'd12,
              32'h0000_0100, 1'b0, 1'b0, 1'b0);
        a_one("lhu_even", LOAD,   3'b101, 32'h0000_0102, 32'h0, 32'h0, 5'd13,
              32'h0000_0102, 1'b0, 1'b0, 1'b0);
        a_one("ld_ill",   LOAD,   3'b011, 32'h0000_0040, 32'h0, 32'h0, 5'd14,
              32'h0000_0040, 1'b0, 1'b1, 1'b0);

        // dut_c: XLEN=64
        c_one("auipc64", AUIPC, 3'b000, 64'h0, 64'hFFFF_FFFF_FFFF_FFF0, 64'h20, 5'd1,
              64'h10, 1'b0, 1'b0, 1'b1);
        c_one("lw64_x32", LOAD, 3'b010, 64'h0000_0000_FFFF_FFFF, 64'h0, 64'h1, 5'd2,
              64'h0000_0001_0000_0000, 1'b0, 1'b0, 1'b0);
        c_one("ld64_ill", LOAD, 3'b011, 64'h8, 64'h0, 64'h0, 5'd3,
              64'h8, 1'b0, 1'b1, 1'b0);
        c_one("jal64_mis", JAL, 3'b000, 64'h0, 64'h1000, 64'h2, 5'd4,
              64'h1002, 1'b1, 1'b0, 1'b0);

        // dut_b: latency 2, C_EXT=1
        set_b(JALR, 3'b000, 32'h8000_0001, 32'h0, 32'h0000_0002, 5'd9);
        #1 check("b_jalr_rdy", ifb.in_ready, 1'b1);
        tick();
        ifb.in_valid = 1'b0;
        check("b_jalr_lat1", ifb.out_valid, 1'b0);
        tick();
        check("b_jalr_vld",  ifb.out_valid, 1'b1);
        check("b_jalr_addr", ifb.address, 32'h8000_0002);
        check("b_jalr_mis",  ifb.misaligned, 1'b0);
        check("b_jalr_tag",  ifb.tag_out, 5'd9);
        tick();

        // Back-to-back STORE stream, out_ready held high
        for (int k = 0; k <= 8; k++) begin
            if (k < 8) set_b(STORE, 3'b010, 32'h1000 + 32'(k * 16), 32'h0, 32'(k), 5'(k));
            else       ifb.in_valid = 1'b0;
            #1;
            if (k < 8) check("strm_rdy", ifb.in_ready, 1'b1);
            tick();
            check("strm_vld", ifb.out_valid, k >= 1);
            if (k >= 1) begin
                e32 = 32'h1000 + 32'((k - 1) * 16) + 32'(k - 1);
                check("strm_addr", ifb.address, e32);
                check("strm_mis",  ifb.misaligned, e32[1:0] != 2'b00);
                check("strm_tag",  ifb.tag_out, 5'(k - 1));
            end
        end
        tick();
        check("strm_drain", ifb.out_valid, 1'b0);

        // Stall with the pipe full
        set_b(STORE, 3'b000, 32'h40, 32'h0, 32'h4, 5'd20);
        tick();
        set_b(STORE, 3'b000, 32'h50, 32'h0, 32'h4, 5'd21);
        tick();
        ifb.out_ready = 1'b0;
        set_b(STORE, 3'b000, 32'h60, 32'h0, 32'h4, 5'd22);
        #1 check("stall_rdy0", ifb.in_ready, 1'b0);
        for (int s = 0; s < 3; s++) begin
            tick();
            check("stall_vld",  ifb.out_valid, 1'b1);
            check("stall_addr", ifb.address, 32'h44);
            check("stall_tag",  ifb.tag_out, 5'd20);
            check("stall_rdy",  ifb.in_ready, 1'b0);
        end
        ifb.out_ready = 1'b1;
        #1 check("rel_rdy", ifb.in_ready, 1'b1);
        tick();
        ifb.in_valid = 1'b0;
        check("rel_tag1",  ifb.tag_out, 5'd21);
        check("rel_addr1", ifb.address, 32'h54);
        tick();
        check("rel_tag2",  ifb.tag_out, 5'd22);
        check("rel_addr2", ifb.address, 32'h64);
        check("rel_vld2",  ifb.out_valid, 1'b1);
        tick();
        check("rel_empty", ifb.out_valid, 1'b0);

        // Flush with two entries in flight
        set_b(LOAD, 3'b000, 32'h70, 32'h0, 32'h0, 5'd23);
        tick();
        set_b(LOAD, 3'b000, 32'h74, 32'h0, 32'h0, 5'd24);
        tick();
        check("fl_pre_vld", ifb.out_valid, 1'b1);
        set_b(LOAD, 3'b000, 32'h78, 32'h0, 32'h0, 5'd25);
        flush = 1'b1;
        #1 check("fl_rdy", ifb.in_ready, 1'b0);
        tick();
        flush = 1'b0;
        ifb.in_valid = 1'b0;
        check("fl_vld0", ifb.out_valid, 1'b0);
        tick();
        check("fl_vld1", ifb.out_valid, 1'b0);

        // Reset mid-stream
        set_b(BRANCH, 3'b000, 32'h0, 32'hFFFF_FFF0, 32'h20, 5'd26);
        tick();
        set_b(LOAD, 3'b010, 32'h80, 32'h0, 32'h4, 5'd27);
        tick();
        check("mr_vld",  ifb.out_valid, 1'b1);
        check("mr_addr", ifb.address, 32'h10);
        check("mr_co",   ifb.carry_out, 1'b1);
        reset = 1'b0;
        #1 check("mr_rdy", ifb.in_ready, 1'b0);
        tick();
        check("mr_rst_vld",  ifb.out_valid, 1'b0);
        check("mr_rst_addr", ifb.address, 32'h0);
        check("mr_rst_co",   ifb.carry_out, 1'b0);
        check("mr_rst_tag",  ifb.tag_out, 5'd0);
        check("mr_rst_mis",  ifb.misaligned, 1'b0);
        check("mr_rst_ill",  ifb.illegal, 1'b0);
        reset = 1'b1;
        ifb.in_valid = 1'b0;
        tick();
        check("mr_post_vld", ifb.out_valid, 1'b0);
        tick();
        check("mr_post_vld2", ifb.out_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
